// File: rtl/gcd_req_sequencer.sv
// gcd_req_sequencer
//   Front-end for a subtractive GCD datapath/controller pair. Operand pairs
//   arrive over valid/ready and are buffered in a 2-entry FIFO. Each pair is
//   sent to the core as a start strobe with A on gcd_data, followed by B on
//   the next cycle. The sequencer then waits for done and returns the result
//   over valid/ready. Pairs containing a zero never reach the core, because a
//   subtractive core would never terminate on them. A watchdog aborts a core
//   that hangs and reports the result with out_err set.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready      operand pair handshake; in_ready = FIFO not full
//   in_a, in_b             operands
//   gcd_start, gcd_data    start strobe and serial operand bus to the core
//   gcd_done, gcd_result   done flag and A register from the core
//   out_valid/out_ready    result handshake
//   out_gcd, out_err       result value and timeout flag
module gcd_req_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_A   = 3'd1,
    LOAD_B   = 3'd2,
    WAIT     = 3'd3,
    DONE_BYP = 3'd4,
    OUT      = 3'd5
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  fifo_a [2];
  logic [WIDTH-1:0]  fifo_b [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [1:0]        count_nxt;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [WD_W-1:0]   wdog;
  logic              push;
  logic              pop;
  logic [WIDTH-1:0]  head_a;
  logic [WIDTH-1:0]  head_b;

  assign push   = in_valid && in_ready;
  assign pop    = (state == IDLE) && (count != 2'd0);
  assign head_a = fifo_a[rd_ptr];
  assign head_b = fifo_b[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push && !pop) count_nxt = count + 2'd1;
    else if (pop && !push) count_nxt = count - 2'd1;
  end

  // Stage: pair FIFO (storage carries no reset; only pointers and count do)
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= in_a;
      fifo_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      in_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count    <= count_nxt;
      // Registered full flag; a push and a pop together cannot occur when full.
      in_ready <= (count_nxt != 2'd2);
    end
  end

  // Stage: operand latch for the transfer in flight
  always_ff @(posedge clk) begin
    if (pop) begin
      op_a <= head_a;
      op_b <= head_b;
    end
  end

  // Stage: transfer sequencer with registered core and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gcd_start <= 1'b0;
      gcd_data  <= '0;
      out_valid <= 1'b0;
      out_gcd   <= '0;
      out_err   <= 1'b0;
      wdog      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != 2'd0) begin
            if (head_a == '0 || head_b == '0) begin
              state <= DONE_BYP;
            end else begin
              state     <= LOAD_A;
              gcd_start <= 1'b1;
              gcd_data  <= head_a;
            end
          end
        end
        LOAD_A: begin
          gcd_start <= 1'b0;
          gcd_data  <= op_b;
          state     <= LOAD_B;
        end
        LOAD_B: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Done wins over a timeout that lands on the same cycle.
          if (gcd_done) begin
            out_gcd   <= gcd_result;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= OUT;
          end else if (wdog == WD_W'(TIMEOUT - 1)) begin
            out_gcd   <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        DONE_BYP: begin
          // gcd(x,0) = x and gcd(0,0) = 0, so OR gives the answer directly.
          out_gcd   <= op_a | op_b;
          out_err   <= 1'b0;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_req_sequencer.sv
// Testbench for gcd_req_sequencer: behavioural GCD core stub, scoreboard of
// expected results and directed plus random stimulus.
module tb_gcd_req_sequencer;

  localparam int W  = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_a, in_b;
  logic          gcd_start;
  logic [W-1:0]  gcd_data;
  logic          gcd_done;
  logic [W-1:0]  gcd_result;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_gcd;
  logic          out_err;

  gcd_req_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .gcd_start(gcd_start), .gcd_data(gcd_data),
    .gcd_done(gcd_done), .gcd_result(gcd_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_gcd(out_gcd), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  // ---------------- behavioural core stub ----------------
  logic [W-1:0] core_a, core_b, core_res;
  int           core_cnt;
  int           core_phase;
  bit           core_hang = 1'b0;
  int           core_lat_fixed = -1;

  assign gcd_result = core_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_phase <= 0;
      core_cnt   <= 0;
      gcd_done   <= 1'b0;
      core_res   <= '0;
    end else begin
      gcd_done <= 1'b0;
      if (gcd_start) begin
        core_a     <= gcd_data;
        core_phase <= 1;
      end else if (core_phase == 1) begin
        core_b     <= gcd_data;
        core_cnt   <= (core_lat_fixed >= 0) ? core_lat_fixed : int'($urandom_range(0, 8));
        core_phase <= 2;
      end else if (core_phase == 2 && !core_hang) begin
        if (core_cnt == 0) begin
          gcd_done   <= 1'b1;
          core_res   <= ref_gcd(core_a, core_b);
          core_phase <= 0;
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [W-1:0] g;
    logic         e;
  } exp_t;

  exp_t sbq[$];
  int   start_pulses = 0;
  logic start_prev;
  bit   holding;
  logic [W-1:0] held_g;
  logic held_e;

  function automatic exp_t mk_exp(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    if (a == 0 || b == 0) begin
      r.g = a | b; r.e = 1'b0;
    end else if (core_hang) begin
      r.g = '0;    r.e = 1'b1;
    end else begin
      r.g = ref_gcd(a, b); r.e = 1'b0;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      holding    <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      if (gcd_start) begin
        chk("start_pulse_width", {31'd0, start_prev}, 32'd0);
        start_pulses++;
      end
      start_prev <= gcd_start;
      if (out_valid) begin
        if (holding) begin
          chk("hold_gcd", {16'd0, out_gcd}, {16'd0, held_g});
          chk("hold_err", {31'd0, out_err}, {31'd0, held_e});
        end
        if (out_ready) begin
          if (sbq.size() == 0) begin
            chk("unexpected_result", {31'd0, out_valid}, 32'd0);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("result_gcd", {16'd0, out_gcd}, {16'd0, e.g});
            chk("result_err", {31'd0, out_err}, {31'd0, e.e});
          end
        end
      end
      holding <= out_valid && !out_ready;
      held_g  <= out_gcd;
      held_e  <= out_err;
      if (in_valid && in_ready) sbq.push_back(mk_exp(in_a, in_b));
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1; in_a = a; in_b = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) chk("push_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_start(output int k);
    k = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (gcd_start) begin k = i; break; end
    end
    if (k == 0) chk("start_timeout", {31'd0, gcd_start}, 32'd1);
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_valid) begin k = i; break; end
    end
    if (k == 0) chk("valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("drain_timeout", sbq.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] rnd_op();
    int r;
    r = int'($urandom_range(0, 5));
    if (r == 0) return '0;
    if (r == 1) return W'($urandom_range(1, 60));
    return W'($urandom);
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
    chk({tag, "_gcd_start"}, {31'd0, gcd_start}, 32'd0);
    chk({tag, "_gcd_data"},  {16'd0, gcd_data},  32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_gcd"},   {16'd0, out_gcd},   32'd0);
    chk({tag, "_out_err"},   {31'd0, out_err},   32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k, sp;
    bit rnd_done;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic transfer and core protocol
    push_pair(16'd143, 16'd78);
    wait_start(k);
    chk("t1_data_a", {16'd0, gcd_data}, 32'd143);
    @(negedge clk);
    chk("t1_start_low", {31'd0, gcd_start}, 32'd0);
    chk("t1_data_b", {16'd0, gcd_data}, 32'd78);
    wait_drain(100);

    // Zero-operand bypass
    sp = start_pulses;
    push_pair(16'd0, 16'd25);
    wait_valid(k);
    chk("byp1_latency", k, 32'd3);
    @(posedge clk); #1;
    push_pair(16'd0, 16'd0);
    wait_valid(k);
    chk("byp2_latency", k, 32'd3);
    wait_drain(50);
    chk("byp_no_start", start_pulses, sp);

    // FIFO fills during a long transfer
    core_lat_fixed = 12;
    push_pair(16'd65535, 16'd1);
    push_pair(16'd48, 16'd18);
    push_pair(16'd7, 16'd7);
    @(negedge clk);
    chk("fifo_full_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    wait_drain(300);
    core_lat_fixed = -1;

    // Back-pressure on the result
    out_ready = 1'b0;
    push_pair(16'd30, 16'd12);
    push_pair(16'd9, 16'd6);
    wait_valid(k);
    sp = start_pulses;
    repeat (20) @(negedge clk);
    chk("hold_valid", {31'd0, out_valid}, 32'd1);
    chk("hold_no_start", start_pulses, sp);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain(100);

    // Watchdog timeout with a hung core
    core_hang = 1'b1;
    push_pair(16'd100, 16'd35);
    wait_start(k);
    wait_valid(k);
    chk("timeout_latency", k, 32'd18);
    wait_drain(50);
    core_hang = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Reset in the middle of WAIT
    core_lat_fixed = 10;
    push_pair(16'd84, 16'd36);
    wait_start(k);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sbq.delete();
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    core_lat_fixed = -1;
    @(posedge clk); #1;
    push_pair(16'd20, 16'd8);
    wait_drain(100);

    // Randomised traffic with random back-pressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          push_pair(rnd_op(), rnd_op());
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain(2000);
    chk("final_queue_empty", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
